// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types for the mux select arbiter: channel count, FSM states, channel index.
package mux_sel_arbiter_pkg;

    localparam int unsigned NCH = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // 0 = ch1, 1 = ch2, 2 = ch3
    typedef logic [1:0] ch_idx_t;

    function automatic ch_idx_t onehot_to_idx(logic [NCH-1:0] oh);
        ch_idx_t idx;
        idx = 2'd0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (oh[i]) idx = ch_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first full channel after 'last', order ch1->ch2->ch3->ch1.
module mux_sel_arbiter_rr_pick
    import mux_sel_arbiter_pkg::*;
(
    input  logic [NCH-1:0] full,
    input  ch_idx_t        last,
    output logic           gnt_valid,
    output ch_idx_t        gnt_idx
);

    always_comb begin
        ch_idx_t cand;
        gnt_valid = 1'b0;
        gnt_idx   = last;
        cand      = last;
        for (int k = 1; k <= int'(NCH); k++) begin
            cand = ch_idx_t'((32'(last) + 32'(k)) % NCH);
            if (!gnt_valid && full[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Three-channel one-word buffers with round-robin select generation for the priority mux.
// Optional concurrent checks compiled in with MUX_SEL_ARBITER_ASSERT_EN.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int unsigned DW   = 4,
    parameter int unsigned HOLD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req1_valid,
    input  logic          req2_valid,
    input  logic          req3_valid,
    input  logic [DW-1:0] req1_data,
    input  logic [DW-1:0] req2_data,
    input  logic [DW-1:0] req3_data,
    output logic          req1_ready,
    output logic          req2_ready,
    output logic          req3_ready,
    output logic [DW-1:0] ip1,
    output logic [DW-1:0] ip2,
    output logic [DW-1:0] ip3,
    output logic          sel1,
    output logic          sel2,
    output logic          sel3,
    output logic          busy
);

    logic [NCH-1:0] valid_in;
    logic [DW-1:0]  data_in [NCH];
    logic [NCH-1:0] full_q, full_d;
    logic [NCH-1:0] sel_q, sel_d;
    logic [DW-1:0]  ip_q [NCH];
    logic [DW-1:0]  ip_d [NCH];
    arb_state_t     state_q, state_d;
    logic [3:0]     hold_q, hold_d;
    ch_idx_t        last_q, last_d;
    logic           gnt_valid;
    ch_idx_t        gnt_idx;

    assign valid_in   = {req3_valid, req2_valid, req1_valid};
    assign data_in[0] = req1_data;
    assign data_in[1] = req2_data;
    assign data_in[2] = req3_data;

    assign req1_ready = ~full_q[0];
    assign req2_ready = ~full_q[1];
    assign req3_ready = ~full_q[2];
    assign ip1        = ip_q[0];
    assign ip2        = ip_q[1];
    assign ip3        = ip_q[2];
    assign sel1       = sel_q[0];
    assign sel2       = sel_q[1];
    assign sel3       = sel_q[2];
    assign busy       = (state_q == GRANT);

    mux_sel_arbiter_rr_pick u_rr_pick (
        .full      (full_q),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        full_d  = full_q;
        ip_d    = ip_q;
        sel_d   = sel_q;
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;

        for (int i = 0; i < int'(NCH); i++) begin
            if (valid_in[i] && !full_q[i]) begin
                full_d[i] = 1'b1;
                ip_d[i]   = data_in[i];
            end
        end

        unique case (state_q)
            IDLE: begin
                sel_d = '0;
                if (gnt_valid) begin
                    sel_d[gnt_idx] = 1'b1;
                    hold_d         = 4'(HOLD - 1);
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                if (hold_q == 4'd0) begin
                    // Only the granted (full) buffer is freed; fresh loads elsewhere survive.
                    full_d  = full_d & ~sel_q;
                    last_d  = onehot_to_idx(sel_q);
                    sel_d   = '0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q  <= '0;
            sel_q   <= '0;
            state_q <= IDLE;
            hold_q  <= 4'd0;
            last_q  <= ch_idx_t'(NCH - 1);
            for (int i = 0; i < int'(NCH); i++) ip_q[i] <= '0;
        end else begin
            full_q  <= full_d;
            sel_q   <= sel_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            for (int i = 0; i < int'(NCH); i++) ip_q[i] <= ip_d[i];
        end
    end

`ifdef MUX_SEL_ARBITER_ASSERT_EN
    a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel_q));

    for (genvar c = 0; c < int'(NCH); c++) begin : g_chk
        a_sel_hold: assert property (@(posedge clk) disable iff (!rst_n)
            $rose(sel_q[c]) |-> sel_q[c] [*HOLD] ##1 !sel_q[c]);
        a_ip_stable: assert property (@(posedge clk) disable iff (!rst_n)
            sel_q[c] |-> $stable(ip_q[c]));
        a_ready_low: assert property (@(posedge clk) disable iff (!rst_n)
            sel_q[c] |-> full_q[c]);
    end
`endif

endmodule
